// File: rtl/reciprocal_unit_core.sv
// Fixed-latency reciprocal: trunc(2^24 / X_in) by a bit-serial restoring divider
// working on |X_in|, with sign restore and symmetric saturation on the way out.
module reciprocal_unit_core #(
  parameter int INPUT_X_WIDTH   = 24,
  parameter int DIVISOR_WIDTH   = 24,
  parameter int QUOTIENT_WIDTH  = 24,
  parameter int FINAL_OUT_WIDTH = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [INPUT_X_WIDTH-1:0]   X_in,
  input  logic                              valid_in,
  output logic signed [FINAL_OUT_WIDTH-1:0] reciprocal_out,
  output logic                              valid_out
);

  // The dividend 2^QUOTIENT_WIDTH has QUOTIENT_WIDTH+1 bits, one quotient bit each.
  localparam int NUM_ITER = QUOTIENT_WIDTH + 1;
  localparam int CNT_W    = $clog2(NUM_ITER + 1);
  localparam logic [CNT_W-1:0]           LAST_ITER = CNT_W'(NUM_ITER - 1);
  localparam logic [FINAL_OUT_WIDTH-1:0] SAT_MAG   = {1'b0, {(FINAL_OUT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       sign_q;
  logic [DIVISOR_WIDTH-1:0]   divisor_q;
  logic [DIVISOR_WIDTH-1:0]   rem_q;
  logic [NUM_ITER-1:0]        quo_q;
  logic [CNT_W-1:0]           count_q;

  logic [INPUT_X_WIDTH-1:0]   x_bits;
  logic [INPUT_X_WIDTH-1:0]   x_mag;
  logic [DIVISOR_WIDTH:0]     rem_shift;
  logic                       rem_ge;
  logic [DIVISOR_WIDTH-1:0]   rem_sub;
  logic                       quo_sat;
  logic [FINAL_OUT_WIDTH-1:0] mag_out;
  logic [FINAL_OUT_WIDTH-1:0] result;

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_in) state_d = DIVIDE;
      DIVIDE:  if (count_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_bits = X_in;
    x_mag  = x_bits[INPUT_X_WIDTH-1] ? (~x_bits + {{(INPUT_X_WIDTH-1){1'b0}}, 1'b1}) : x_bits;

    // Only the dividend MSB is set, so the bit shifted in is 1 on the first step only.
    rem_shift = {rem_q, (count_q == '0)};
    rem_ge    = rem_shift >= {1'b0, divisor_q};
    // The difference is below the divisor, so dropping the top bit is exact.
    rem_sub   = rem_shift[DIVISOR_WIDTH-1:0] - divisor_q;

    // A zero divisor yields an all-ones quotient, which lands on +max here.
    quo_sat = quo_q > NUM_ITER'(SAT_MAG);
    mag_out = quo_sat ? SAT_MAG : FINAL_OUT_WIDTH'(quo_q);
    result  = sign_q ? (~mag_out + {{(FINAL_OUT_WIDTH-1){1'b0}}, 1'b1}) : mag_out;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      divisor_q      <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      count_q        <= '0;
      reciprocal_out <= '0;
      valid_out      <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_out <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid_in) begin
            sign_q    <= x_bits[INPUT_X_WIDTH-1];
            divisor_q <= DIVISOR_WIDTH'(x_mag);
            rem_q     <= '0;
            quo_q     <= '0;
            count_q   <= '0;
          end
        end
        DIVIDE: begin
          rem_q   <= rem_ge ? rem_sub : rem_shift[DIVISOR_WIDTH-1:0];
          quo_q   <= {quo_q[NUM_ITER-2:0], rem_ge};
          count_q <= count_q + CNT_W'(1);
        end
        DONE: begin
          reciprocal_out <= result;
          valid_out      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reciprocal_unit_core.sv
// Self-checking bench for reciprocal_unit_core: directed spec vectors, random
// divisors against an integer-division model, busy-ignore, back-to-back and reset abort.
module tb_reciprocal_unit_core;

  localparam int LATENCY = 26;
  localparam int BUDGET  = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [23:0] X_in;
  logic               valid_in;
  logic signed [23:0] reciprocal_out;
  logic               valid_out;

  int tests_run    = 0;
  int tests_failed = 0;

  reciprocal_unit_core dut (
    .clk            (clk),
    .rst            (rst),
    .X_in           (X_in),
    .valid_in       (valid_in),
    .reciprocal_out (reciprocal_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  // Reference: signed integer division of 2^24, truncated toward zero, saturated.
  function automatic logic [23:0] model(input logic [23:0] x);
    longint sx, mag, q;
    sx  = longint'($signed(x));
    mag = (sx < 0) ? -sx : sx;
    if (mag == 0) return 24'h7FFFFF;
    q = (longint'(1) << 24) / mag;
    if (q > 64'sh7FFFFF) q = 64'sh7FFFFF;
    if (sx < 0) q = -q;
    return q[23:0];
  endfunction

  // Issues one request, changes X_in after acceptance, checks latency, value and pulse width.
  task automatic run_request(input logic [23:0] x, input logic [23:0] exp, input string name);
    int lat;
    @(negedge clk);
    X_in     = x;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    X_in     = 24'($urandom);
    lat = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        lat = n;
        break;
      end
    end
    tests_run++;
    if (lat !== LATENCY) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d, expected %0d (0 = timeout)", name, lat, LATENCY);
    end
    tests_run++;
    if (reciprocal_out !== exp) begin
      tests_failed++;
      $display("FAIL %s value: X=%h got %h, expected %h", name, x, reciprocal_out, exp);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (valid_out !== 1'b0 || reciprocal_out !== exp) begin
      tests_failed++;
      $display("FAIL %s hold: valid_out=%b out=%h, expected 0 / %h", name, valid_out, reciprocal_out, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0; X_in = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (valid_out !== 1'b0 || reciprocal_out !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset state: valid_out=%b out=%h, expected 0 / 000000", valid_out, reciprocal_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [23:0] xs   [13] = '{24'h000400, 24'h000200, 24'h010000, 24'h008000, 24'd2783, 24'd16777,
                               24'hFFF000, 24'h000000, 24'h000001, 24'hFFFFFF, 24'h000002, 24'hFFFFFE,
                               24'h000003};
    logic [23:0] exps [13] = '{24'h004000, 24'h008000, 24'h000100, 24'h000200, 24'd6028, 24'd1000,
                               24'hFFF000, 24'h7FFFFF, 24'h7FFFFF, 24'h800001, 24'h7FFFFF, 24'h800001,
                               24'h555555};
    for (int i = 0; i < 13; i++) run_request(xs[i], exps[i], $sformatf("directed[%0d]", i));
  endtask

  task automatic test_random;
    logic [23:0] x;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) begin
        x = 24'($urandom_range(0, 8));
        if ($urandom_range(0, 1) == 1) x = ~x + 24'd1;
      end else begin
        x = 24'($urandom);
      end
      run_request(x, model(x), $sformatf("random[%0d]", i));
    end
  endtask

  // A request held during DIVIDE is ignored; a request right after the result is accepted.
  task automatic test_back_to_back;
    int pulses, first, lat;
    @(negedge clk);
    X_in = 24'h001000; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    pulses = 0; first = 0;
    for (int n = 1; n <= LATENCY; n++) begin
      if (n >= 5 && n <= 9) begin valid_in = 1'b1; X_in = 24'h000400; end
      else valid_in = 1'b0;
      @(posedge clk);
      #1;
      if (valid_out) begin pulses++; if (first == 0) first = n; end
    end
    tests_run++;
    if (first !== LATENCY || reciprocal_out !== 24'h001000) begin
      tests_failed++;
      $display("FAIL b2b first: latency %0d value %h, expected %0d / 001000", first, reciprocal_out, LATENCY);
    end
    // Back-to-back request presented in the cycle right after DONE.
    valid_in = 1'b1; X_in = 24'h000200;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    lat = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    tests_run++;
    if (lat !== LATENCY || reciprocal_out !== 24'h008000) begin
      tests_failed++;
      $display("FAIL b2b second: latency %0d value %h, expected %0d / 008000", lat, reciprocal_out, LATENCY);
    end
    tests_run++;
    if (pulses !== 2) begin
      tests_failed++;
      $display("FAIL b2b pulse count: got %0d, expected 2", pulses);
    end
  endtask

  // Reset at iteration 10 aborts silently; release with valid_in high starts a fresh request.
  task automatic test_reset_mid;
    int lat, early;
    @(negedge clk);
    X_in = 24'h000400; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (valid_out !== 1'b0 || reciprocal_out !== 24'h0) begin
      tests_failed++;
      $display("FAIL mid reset: valid_out=%b out=%h, expected 0 / 000000", valid_out, reciprocal_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; valid_in = 1'b1; X_in = 24'h008000;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    lat = 0; early = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (valid_out && lat == 0) lat = n;
      if (n < LATENCY && (valid_out || reciprocal_out !== 24'h0)) early++;
    end
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("FAIL abort: %0d cycles with stray output, expected 0", early);
    end
    tests_run++;
    if (lat !== LATENCY || reciprocal_out !== 24'h000200) begin
      tests_failed++;
      $display("FAIL post-reset: latency %0d value %h, expected %0d / 000200", lat, reciprocal_out, LATENCY);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
